// File: rtl/mem_access_pkg.sv
//==============================================================================
// Module      : mem_access_pkg
// Description : Shared pipeline constants, memory-op/size encodings and the
//               memory-access state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int c_XLEN_DEFAULT  = 32;
    localparam int c_REG_ADDR_W    = 5;

    // Encoding 3 is reserved and behaves as NONE.
    typedef logic [1:0] mem_op_t;
    localparam mem_op_t c_MEM_OP_NONE  = 2'd0;
    localparam mem_op_t c_MEM_OP_LOAD  = 2'd1;
    localparam mem_op_t c_MEM_OP_STORE = 2'd2;

    typedef logic [1:0] mem_size_t;
    localparam mem_size_t c_MEM_SIZE_B = 2'd0;
    localparam mem_size_t c_MEM_SIZE_H = 2'd1;
    localparam mem_size_t c_MEM_SIZE_W = 2'd2;
    localparam mem_size_t c_MEM_SIZE_D = 2'd3;

    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE = 1'b0;
    localparam state_t c_ST_BUSY = 1'b1;

    // Doubleword accesses only exist on a 64-bit datapath.
    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] lo,
                                           input logic xlen64);
        is_misaligned = 1'b0;
        case (size)
            c_MEM_SIZE_H: is_misaligned = lo[0];
            c_MEM_SIZE_W: is_misaligned = |lo[1:0];
            c_MEM_SIZE_D: is_misaligned = !xlen64 || (|lo);
            default:      is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_load_align.sv
//==============================================================================
// Module      : load_align
// Description : Extracts the addressed lanes of a read word and sign- or
//               zero-extends them to the datapath width.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_align
    import mem_access_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [OFF_W-1:0] offset_i,
    input  mem_size_t        size_i,
    input  logic             unsigned_i,
    output logic [XLEN-1:0]  result_o
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        result_o = w_shifted;
        case (size_i)
            c_MEM_SIZE_B: begin
                if (unsigned_i) result_o = XLEN'(w_shifted[7:0]);
                else            result_o = XLEN'($signed(w_shifted[7:0]));
            end
            c_MEM_SIZE_H: begin
                if (unsigned_i) result_o = XLEN'(w_shifted[15:0]);
                else            result_o = XLEN'($signed(w_shifted[15:0]));
            end
            c_MEM_SIZE_W: begin
                if (unsigned_i) result_o = XLEN'(w_shifted[31:0]);
                else            result_o = XLEN'($signed(w_shifted[31:0]));
            end
            default: result_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
//==============================================================================
// Module      : mem_access
// Description : Pipeline memory-access stage: passes ALU results through and
//               runs loads/stores over a request/ack memory port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN       = c_XLEN_DEFAULT,
    parameter int REG_ADDR_W = c_REG_ADDR_W,
    parameter int BE_W       = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  w_enable_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    input  logic [XLEN-1:0]       w_data_i,
    input  mem_op_t               mem_op_i,
    input  mem_size_t             mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [XLEN-1:0]       store_data_i,
    output logic                  stall_o,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [XLEN-1:0]       w_data_o,
    output logic                  misalign_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic [BE_W-1:0]       mem_be_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int c_OFF_W = $clog2(BE_W);

    state_t                r_state;
    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic [BE_W-1:0]       r_be;
    mem_size_t             r_size;
    logic                  r_unsigned;
    logic                  r_store;
    logic                  r_wen;
    logic [REG_ADDR_W-1:0] r_waddr;

    logic                  w_is_mem;
    logic                  w_misalign;
    logic                  w_start;
    logic [BE_W-1:0]       w_size_mask;
    logic [BE_W-1:0]       w_be;
    logic [XLEN-1:0]       w_wdata_rep;
    logic [XLEN-1:0]       w_load_data;

    assign w_is_mem   = (mem_op_i == c_MEM_OP_LOAD) || (mem_op_i == c_MEM_OP_STORE);
    assign w_misalign = is_misaligned(mem_size_i, w_data_i[2:0], XLEN == 64);
    assign w_start    = valid_i && w_is_mem && !w_misalign;

    always_comb begin
        w_size_mask = BE_W'(1);
        w_wdata_rep = {BE_W{store_data_i[7:0]}};
        case (mem_size_i)
            c_MEM_SIZE_H: begin
                w_size_mask = BE_W'(3);
                w_wdata_rep = {(XLEN/16){store_data_i[15:0]}};
            end
            c_MEM_SIZE_W: begin
                w_size_mask = BE_W'(15);
                w_wdata_rep = {(XLEN/32){store_data_i[31:0]}};
            end
            c_MEM_SIZE_D: begin
                w_size_mask = '1;
                w_wdata_rep = store_data_i;
            end
            default: begin
                w_size_mask = BE_W'(1);
                w_wdata_rep = {BE_W{store_data_i[7:0]}};
            end
        endcase
    end

    assign w_be = w_size_mask << w_data_i[c_OFF_W-1:0];

    // Memory port is driven only from latched state so it stays stable until ack.
    assign mem_req_o   = (r_state == c_ST_BUSY);
    assign mem_we_o    = mem_req_o && r_store;
    assign mem_addr_o  = {r_addr[XLEN-1:c_OFF_W], {c_OFF_W{1'b0}}};
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;
    assign stall_o     = (r_state == c_ST_IDLE) ? w_start : !mem_ack_i;

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (c_OFF_W)
    ) u_load_align (
        .rdata_i    (mem_rdata_i),
        .offset_i   (r_addr[c_OFF_W-1:0]),
        .size_i     (r_size),
        .unsigned_i (r_unsigned),
        .result_o   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            w_enable_o <= 1'b0;
            w_addr_o   <= '0;
            w_data_o   <= '0;
            misalign_o <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_size     <= c_MEM_SIZE_B;
            r_unsigned <= 1'b0;
            r_store    <= 1'b0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
        end else begin
            misalign_o <= 1'b0;
            w_enable_o <= 1'b0;
            w_addr_o   <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (valid_i) begin
                        if (!w_is_mem) begin
                            w_enable_o <= w_enable_i;
                            w_addr_o   <= w_enable_i ? w_addr_i : '0;
                            w_data_o   <= w_data_i;
                        end else if (w_misalign) begin
                            misalign_o <= 1'b1;
                        end else begin
                            r_state    <= c_ST_BUSY;
                            r_addr     <= w_data_i;
                            r_wdata    <= w_wdata_rep;
                            r_be       <= w_be;
                            r_size     <= mem_size_i;
                            r_unsigned <= mem_unsigned_i;
                            r_store    <= (mem_op_i == c_MEM_OP_STORE);
                            r_wen      <= w_enable_i;
                            r_waddr    <= w_addr_i;
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (mem_ack_i) begin
                        r_state <= c_ST_IDLE;
                        if (!r_store) begin
                            w_enable_o <= r_wen;
                            w_addr_o   <= r_wen ? r_waddr : '0;
                            w_data_o   <= w_load_data;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  XLEN, 32, datapath width; legal values 32 and 64.
  REG_ADDR_W, 5, register-address width.
  BE_W, XLEN/8, byte-enable width (derived).
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  clock, rising edge.
  rst  in  1  reset, synchronous, active-high.
  valid_i  in  1  EX result present this cycle.
  w_enable_i  in  1  writeback requested.
  w_addr_i  in  REG_ADDR_W  destination register.
  w_data_i  in  XLEN  ALU result, or effective address for memory ops.
  mem_op_i  in  2  0 NONE, 1 LOAD, 2 STORE, 3 reserved (treated as NONE).
  mem_size_i  in  2  0 B, 1 H, 2 W, 3 D.
  mem_unsigned_i  in  1  load zero-extends when 1.
  store_data_i  in  XLEN  store operand.
  stall_o  out  1  hold upstream inputs stable.
  w_enable_o  out  1  registered to WB.
  w_addr_o  out  REG_ADDR_W  registered to WB.
  w_data_o  out  XLEN  registered to WB.
  misalign_o  out  1  registered one-cycle exception pulse.
  mem_req_o  out  1  memory request.
  mem_we_o  out  1  write strobe.
  mem_addr_o  out  XLEN  address aligned to XLEN/8 bytes.
  mem_be_o  out  BE_W  byte lanes.
  mem_wdata_o  out  XLEN  store data, replicated into lanes.
  mem_rdata_i  in  XLEN  read data, valid with ack.
  mem_ack_i  in  1  request completed.

Function
REQ-003 FSM shall have states IDLE and BUSY; reset state IDLE.
REQ-004 IDLE, valid_i, op NONE: the next edge shall register w_enable_i/w_addr_i/w_data_i to the outputs; stall_o=0; latency 1 cycle.
REQ-005 IDLE, valid_i, op LOAD/STORE, aligned: stall_o=1 combinationally; the next edge shall latch the op, address, size, data and destination, go to BUSY, and drive w_enable_o=0 (bubble).
REQ-006 Alignment rule: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0 and XLEN=64; D with XLEN=32 is misaligned.
REQ-007 Misaligned op in IDLE: no memory request; the next edge shall set misalign_o=1 for one cycle and w_enable_o=0; stall_o=0.
REQ-008 BUSY: mem_req_o=1 and mem_addr_o/mem_be_o/mem_we_o/mem_wdata_o held constant from latched values until mem_ack_i; the interface shall ignore inputs; stall_o = !mem_ack_i.
REQ-009 mem_be_o: size mask (1/2/4/8 lanes) shifted by the low address bits; mem_wdata_o: store_data low bytes replicated across the word.
REQ-010 Ack in BUSY: the same edge shall return the FSM to IDLE; a LOAD shall register w_enable_o=latched w_enable, w_data_o=extracted lanes, sign- or zero-extended to XLEN; a STORE shall force w_enable_o=0.
REQ-011 An ack at the first BUSY cycle is legal, giving a minimum load latency of 2 cycles from presentation; mem_ack_i in IDLE shall be ignored.
REQ-012 valid_i=0 in IDLE: next edge w_enable_o=0, misalign_o=0.
REQ-013 w_addr_o shall be driven as 0 whenever w_enable_o=0.

Reset
REQ-014 rst shall force state IDLE, w_enable_o=0, w_addr_o=0, w_data_o=0, misalign_o=0 at the next edge; mem_req_o shall deassert from that edge.
REQ-015 rst during BUSY shall abandon the request without waiting for ack; a late ack shall be ignored.

Structure
REQ-016 mem_op and mem_size encodings and the state enumeration shall live in the shared defines package next to the existing pipeline constants.
REQ-017 Lane extraction and extension shall be a sub-module load_align (inputs: rdata, offset, size, unsigned; output: XLEN result), purely combinational.

Verification
REQ-018 The bench shall cover the following directed scenarios:
  ALU op w_addr=5, w_data=0x1234 -> next cycle w_enable_o=1, w_addr_o=5, w_data_o=0x1234, stall_o=0.
  LB addr 0x103, rdata 0x80AA_BBCC, ack after 3 BUSY cycles -> mem_be_o=0b1000, stall_o high 4 cycles, w_data_o=0xFFFF_FF80; with LBU -> 0x0000_0080.
  SH addr 0x102, store_data 0xBEEF -> mem_be_o=0b1100, mem_wdata_o=0xBEEF_BEEF, mem_we_o=1, w_enable_o=0 after ack.
  LW addr 0x102 -> misalign_o one-cycle pulse, mem_req_o never asserted, stall_o=0.
  XLEN=64, LD addr 0x8, ack at first BUSY cycle -> mem_be_o=0xFF, w_data_o=rdata, total latency 2 cycles.
  rst asserted in BUSY with ack arriving the cycle after reset -> mem_req_o low after the edge, all outputs 0, ack ignored.
